// File: rtl/bcd_credit_sequencer.sv
// Multi-digit BCD credit register that owns a shared single-digit adder.
// Deposit, vend and clear run serially, least significant digit first.
module bcd_credit_sequencer #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [4*DIGITS-1:0] cmd_val,
  output logic [3:0]          add_num_0,
  output logic [3:0]          add_num_1,
  output logic                add_c_in,
  output logic                add_en,
  input  logic [3:0]          add_sum,
  output logic [4*DIGITS-1:0] credit,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] OP_DEP = 2'b00;
  localparam logic [1:0] OP_VND = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   val_q, val_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   scratch_q, scratch_d;
  logic [W-1:0]   credit_q, credit_d;
  logic           rej_q, rej_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           bad;
  logic [4:0]     sum5;
  logic [3:0]     opd_dig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      val_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      scratch_q <= '0;
      credit_q  <= '0;
      rej_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      val_q     <= val_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      scratch_q <= scratch_d;
      credit_q  <= credit_d;
      rej_q     <= rej_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    val_d     = val_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    scratch_d = scratch_q;
    credit_d  = credit_q;
    rej_d     = rej_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    bad       = (cmd_op == OP_RSV);
    for (int i = 0; i < DIGITS; i++) begin
      if (cmd_val[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    sum5 = {1'b0, add_num_0} + {1'b0, add_num_1} + {4'd0, add_c_in};
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          val_d   = cmd_val;
          rej_d   = bad;
          idx_d   = '0;
          carry_d = (cmd_op == OP_VND);
          state_d = (bad || cmd_op == OP_CLR) ? FINISH : RUN;
        end
      end
      RUN: begin
        scratch_d[{idx_q, 2'b00} +: 4] = add_sum;
        carry_d = (sum5 >= 5'd10);
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(DIGITS - 1)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        // deposit overflows on carry-out; vend borrows on missing carry-out
        if (rej_q) begin
          err_d = 1'b1;
        end else if (op_q == OP_CLR) begin
          credit_d = '0;
        end else if ((op_q == OP_DEP && carry_q) ||
                     (op_q == OP_VND && !carry_q)) begin
          err_d = 1'b1;
        end else begin
          credit_d = scratch_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    add_en    = 1'b0;
    add_num_0 = 4'd0;
    add_num_1 = 4'd0;
    add_c_in  = 1'b0;
    opd_dig   = val_q[{idx_q, 2'b00} +: 4];
    if (state_q == RUN) begin
      add_en    = 1'b1;
      add_num_0 = credit_q[{idx_q, 2'b00} +: 4];
      add_num_1 = (op_q == OP_VND) ? (4'd9 - opd_dig) : opd_dig;
      add_c_in  = carry_q;
    end
  end

  assign credit = credit_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: doc/bcd_credit_sequencer.md
Name: bcd_credit_sequencer

Overview:
Controller that owns the vending machine's multi-digit BCD credit register. It services deposit, vend and clear commands by driving one shared single-digit BCD adder (sum = (num_0+num_1+c_in) mod 10) serially, least significant digit first. It sits between the coin/selection front end and the credit display, and is the only block that drives the digit adder.

Parameters:
DIGITS, 3, number of BCD digits in the credit register and in the command operand (range 1..8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when a command can be accepted (state IDLE)
cmd_op  in  2  00 deposit, 01 vend (subtract price), 10 clear, 11 reserved
cmd_val  in  4*DIGITS  BCD operand: coin value or price, digit 0 in [3:0]
add_num_0  out  4  adder operand A (current credit digit)
add_num_1  out  4  adder operand B (operand digit, or its nine's complement)
add_c_in  out  1  adder carry in
add_en  out  1  high in every cycle the controller uses the adder result
add_sum  in  4  adder result digit, combinational from the num/c_in outputs
credit  out  4*DIGITS  committed BCD credit
busy  out  1  high while a command is in progress
done  out  1  one-cycle pulse when a command completes
err  out  1  valid with done: 1 = command rejected, credit unchanged

Behaviour:
- Reset (async, any state): state IDLE, credit 0, digit index 0, carry 0, scratch 0; cmd_ready 1; busy, done, err, add_en, add_c_in 0; add_num_0/add_num_1 0.
- Handshake: command accepted on a rising edge with cmd_valid & cmd_ready. cmd_op and cmd_val are captured at acceptance; later changes are ignored. cmd_ready = (state == IDLE). A done cycle is IDLE, so back-to-back commands are allowed.
- States:
  - IDLE: on acceptance, check the operand.
    - op 11, or any digit of cmd_val > 9: go to FINISH with err = 1.
    - op 10 (clear): go to FINISH with err = 0 and credit cleared.
    - Otherwise go to RUN with digit index 0. The initial carry is 0 for deposit and 1 for vend.
  - RUN: one digit per cycle, with i = index and add_en = 1.
    - add_num_0 = credit digit i.
    - add_num_1 = operand digit i for deposit, or (9 − operand digit i) for vend.
    - add_c_in = carry.
    - Scratch digit i <= add_sum.
    - carry <= (add_num_0 + add_num_1 + add_c_in >= 10), computed locally at 5-bit width.
    - After digit DIGITS−1, go to FINISH.
  - FINISH: lasts one cycle, then IDLE.
    - Deposit with final carry 1: overflow, so err = 1.
    - Vend with final carry 0: borrow, meaning insufficient credit, so err = 1.
    - Otherwise credit <= scratch and err = 0.
    - The credit update is visible in the cycle after FINISH, which is the same cycle done is asserted. done and err are registered and pulse for exactly one cycle.
- Latency, from the accept edge to the done cycle:
  - Deposit and vend: DIGITS + 2 cycles.
  - Clear or rejected command: 2 cycles.
- busy = 1 from the cycle after acceptance through FINISH. add_en = 0 and add_num/c_in = 0 outside RUN.
- Vend price equal to credit: the result is 0, with err = 0.
- Deposit producing an exact 10^DIGITS: overflow, rejected.
- Credit never changes except at a successful FINISH, a clear, or reset.
- Reset asserted mid-RUN: the command is aborted with no done pulse, and credit returns to 0.
- cmd_valid held high while busy: not accepted and not queued. It is accepted when IDLE returns.

Test Plan:
1. DIGITS=3, reset, then deposit 050 -> done after 5 cycles, err 0, credit 050, and add_en high for exactly 3 cycles.
2. From credit 050: deposit 075, then deposit 100 -> credit 125, then 225. During the 125 run, check that digit 0 (0+5) and digit 1 (5+7) produce a carry into digit 2.
3. From credit 225, vend 150 -> credit 075, err 0. Then vend 100 -> err 1, credit stays 075. Then vend 075 -> credit 000, err 0.
4. From credit 950, deposit 050 -> err 1 (overflow), credit stays 950. Then deposit 12A (digit 0xA) -> err 1 after 2 cycles, add_en never high.
5. Clear and reserved op: from credit 300, op 10 -> credit 000 and done after 2 cycles. Op 11 -> err 1.
6. Assert rst in the middle of a deposit RUN -> credit 0, no done pulse, cmd_ready 1 immediately. Also hold cmd_valid during busy -> exactly one command accepted per IDLE.
